// File: rtl/fifo_unloader_if.sv
// Handshake and bus bundle between the FIFO read side, the unloader and the downstream sink.
interface fifo_unloader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned J     = 4
);
  logic                 en;
  logic                 empty;
  logic [WIDTH*J-1:0]   par_in;
  logic                 rd_en;
  logic [WIDTH-1:0]     ser_out;
  logic                 ser_valid;
  logic                 ser_ready;
  logic                 ser_last;
  logic                 busy;

  // Unloader side: consumes FIFO flags/data and the sink's ready, drives pop and stream.
  modport master (
    input  en, empty, par_in, ser_ready,
    output rd_en, ser_out, ser_valid, ser_last, busy
  );

  // Environment side: FIFO plus downstream sink.
  modport slave (
    output en, empty, par_in, ser_ready,
    input  rd_en, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/fifo_unloader.sv
// Pops J-word groups from the parallel FIFO and streams them one word per handshake,
// lowest slice first, reloading on the last handshake so groups run back-to-back.
module fifo_unloader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned J     = 4
) (
  input  logic            clk,
  input  logic            rst,
  fifo_unloader_if.master bus
);
  localparam int unsigned     CBIT = (J > 1) ? $clog2(J) : 1;
  localparam int unsigned     SW   = WIDTH * J;
  localparam logic [CBIT-1:0] LAST = CBIT'(J - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sreg_q, sreg_d;
  logic [CBIT-1:0] cnt_q, cnt_d;
  logic            valid_q;
  logic            last_q;
  logic            hs_c;
  logic            load_c;

  // A word leaves on a handshake; a new group is popped when idle or on the final handshake.
  assign hs_c   = valid_q & bus.ser_ready;
  assign load_c = bus.en & ~bus.empty & ((state_q == IDLE) | (hs_c & (cnt_q == LAST)));

  // Next-state: load wins over the end-of-group return to IDLE.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    if (load_c) begin
      sreg_d  = bus.par_in;
      cnt_d   = '0;
      state_d = SHIFT;
    end else if (hs_c) begin
      if (cnt_q == LAST) begin
        state_d = IDLE;
      end else begin
        sreg_d = sreg_q >> WIDTH;
        cnt_d  = cnt_q + CBIT'(1);
      end
    end
  end

  // State and registered stream flags; reset discards any partial group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_d == SHIFT);
      last_q  <= (state_d == SHIFT) && (cnt_d == LAST);
    end
  end

  // Pop strobe is combinational so the FIFO pointer advances on the loading edge.
  assign bus.rd_en     = rst & load_c;
  assign bus.ser_out   = sreg_q[WIDTH-1:0];
  assign bus.ser_valid = valid_q;
  assign bus.ser_last  = last_q;
  assign bus.busy      = valid_q;
endmodule
